// File: rtl/unidade_controle_if.sv
// Bus between the control unit and the instruction memory / ALU datapath.
// The master is the control unit; the slave is the memory and datapath side.
interface unidade_controle_if;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 2;
  localparam int unsigned OW = 3;

  logic [DW-1:0] instrucao;
  logic          pronto_mem;
  logic          zero;
  logic [DW-1:0] pc;
  logic [OW-1:0] sinal_ula;
  logic [RW-1:0] reg_fonte1;
  logic [RW-1:0] reg_fonte2;
  logic [RW-1:0] reg_destino;
  logic          reg_escrita;
  logic          sel_imediato;
  logic [DW-1:0] imediato;
  logic          parado;

  modport master (
    input  instrucao, pronto_mem, zero,
    output pc, sinal_ula, reg_fonte1, reg_fonte2, reg_destino,
           reg_escrita, sel_imediato, imediato, parado
  );

  modport slave (
    output instrucao, pronto_mem, zero,
    input  pc, sinal_ula, reg_fonte1, reg_fonte2, reg_destino,
           reg_escrita, sel_imediato, imediato, parado
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit of the 8-bit processor: fetch, decode, execute, write-back,
// with skip-if-equal branch resolved from the ALU zero flag and a sticky halt.
module unidade_controle (
  input  logic                clock,
  input  logic                reset,
  unidade_controle_if.master  bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 2;
  localparam int unsigned OW = 3;

  localparam logic [OW-1:0] OP_ADD  = 3'b010;
  localparam logic [OW-1:0] OP_SUB  = 3'b011;
  localparam logic [OW-1:0] OP_ADDI = 3'b101;
  localparam logic [OW-1:0] OP_BEQ  = 3'b110;
  localparam logic [OW-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    BUSCA, DECODIFICA, EXECUTA, ESCRITA, PARADO
  } estado_t;

  estado_t       r_estado, w_estado_prox;
  logic [DW-1:0] r_pc, w_pc_prox;
  logic [DW-1:0] r_ir, w_ir_prox;
  logic [DW-1:0] r_imediato, w_imediato_prox;
  logic [OW-1:0] r_sinal_ula, w_sinal_ula_prox;
  logic [RW-1:0] r_fonte1, w_fonte1_prox;
  logic [RW-1:0] r_fonte2, w_fonte2_prox;
  logic [RW-1:0] r_destino, w_destino_prox;
  logic          r_escrita, w_escrita_prox;
  logic          r_sel_imediato, w_sel_imediato_prox;
  logic          r_parado, w_parado_prox;

  logic [OW-1:0] w_op;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rs;

  assign w_op = r_ir[7:5];
  assign w_rd = r_ir[4:3];
  assign w_rs = r_ir[2:1];

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado       <= BUSCA;
      r_pc           <= '0;
      r_ir           <= '0;
      r_imediato     <= '0;
      r_sinal_ula    <= '0;
      r_fonte1       <= '0;
      r_fonte2       <= '0;
      r_destino      <= '0;
      r_escrita      <= 1'b0;
      r_sel_imediato <= 1'b0;
      r_parado       <= 1'b0;
    end else begin
      r_estado       <= w_estado_prox;
      r_pc           <= w_pc_prox;
      r_ir           <= w_ir_prox;
      r_imediato     <= w_imediato_prox;
      r_sinal_ula    <= w_sinal_ula_prox;
      r_fonte1       <= w_fonte1_prox;
      r_fonte2       <= w_fonte2_prox;
      r_destino      <= w_destino_prox;
      r_escrita      <= w_escrita_prox;
      r_sel_imediato <= w_sel_imediato_prox;
      r_parado       <= w_parado_prox;
    end
  end

  // Next state and next output values; write enable is a single-cycle pulse
  always_comb begin
    w_estado_prox       = r_estado;
    w_pc_prox           = r_pc;
    w_ir_prox           = r_ir;
    w_imediato_prox     = r_imediato;
    w_sinal_ula_prox    = r_sinal_ula;
    w_fonte1_prox       = r_fonte1;
    w_fonte2_prox       = r_fonte2;
    w_destino_prox      = r_destino;
    w_escrita_prox      = 1'b0;
    w_sel_imediato_prox = r_sel_imediato;
    w_parado_prox       = r_parado;

    case (r_estado)
      BUSCA: begin
        if (bus.pronto_mem) begin
          w_ir_prox     = bus.instrucao;
          w_pc_prox     = r_pc + DW'(1);
          w_estado_prox = DECODIFICA;
        end
      end
      DECODIFICA: begin
        w_fonte1_prox       = w_rd;
        w_fonte2_prox       = w_rs;
        w_destino_prox      = w_rd;
        w_imediato_prox     = DW'(r_ir[2:0]);
        w_sel_imediato_prox = (w_op == OP_ADDI);
        case (w_op)
          OP_ADDI: w_sinal_ula_prox = OP_ADD;
          OP_BEQ:  w_sinal_ula_prox = OP_SUB;
          OP_HALT: w_sinal_ula_prox = '0;
          default: w_sinal_ula_prox = w_op;
        endcase
        if (w_op == OP_HALT) begin
          w_parado_prox = 1'b1;
          w_estado_prox = PARADO;
        end else begin
          w_estado_prox = EXECUTA;
        end
      end
      EXECUTA: begin
        if (w_op == OP_BEQ) begin
          if (bus.zero) w_pc_prox = r_pc + DW'(1);
          w_estado_prox = BUSCA;
        end else begin
          w_escrita_prox = 1'b1;
          w_estado_prox  = ESCRITA;
        end
      end
      ESCRITA: w_estado_prox = BUSCA;
      PARADO:  w_estado_prox = PARADO;
      default: w_estado_prox = BUSCA;
    endcase
  end

  assign bus.pc           = r_pc;
  assign bus.sinal_ula    = r_sinal_ula;
  assign bus.reg_fonte1   = r_fonte1;
  assign bus.reg_fonte2   = r_fonte2;
  assign bus.reg_destino  = r_destino;
  assign bus.reg_escrita  = r_escrita;
  assign bus.sel_imediato = r_sel_imediato;
  assign bus.imediato     = r_imediato;
  assign bus.parado       = r_parado;
endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle: reset abort, ALU op, addi,
// beq taken/not taken, memory stall, halt with pc wrap and skip across 255.
module tb_unidade_controle;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  unidade_controle_if bif ();

  unidade_controle dut (
    .clock (clk),
    .reset (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From pc=0: one unskipped beq (pc=1) then 127 skipped beqs land on pc=255
  task automatic run_to_255();
    do_reset();
    bif.instrucao  = 8'hC2;
    bif.pronto_mem = 1'b1;
    bif.zero       = 1'b0;
    repeat (3) tick();
    bif.zero = 1'b1;
    for (int i = 0; i < 127; i++) repeat (3) tick();
    bif.pronto_mem = 1'b0;
    bif.zero       = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bif.pronto_mem = 1'b0;
    bif.instrucao  = 8'h00;
    bif.zero       = 1'b0;

    #3;
    chk("rst_pc", bif.pc, 8'h00);
    chk("rst_ula", 8'(bif.sinal_ula), 8'h0);
    chk("rst_dest", 8'(bif.reg_destino), 8'h0);
    chk("rst_wr", 8'(bif.reg_escrita), 8'h0);
    chk("rst_imm", bif.imediato, 8'h00);
    chk("rst_parado", 8'(bif.parado), 8'h0);
    tick();
    rst = 1'b0;

    // add r2,r2 aborted by reset in EXECUTA
    bif.instrucao  = 8'h54;
    bif.pronto_mem = 1'b1;
    tick();
    chk("abort_pc_fetch", bif.pc, 8'h01);
    tick();
    chk("abort_ula_exec", 8'(bif.sinal_ula), 8'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", bif.pc, 8'h00);
    chk("async_ula", 8'(bif.sinal_ula), 8'h0);
    chk("async_f1", 8'(bif.reg_fonte1), 8'h0);
    chk("async_f2", 8'(bif.reg_fonte2), 8'h0);
    chk("async_wr", 8'(bif.reg_escrita), 8'h0);
    tick();
    chk("held_rst_wr", 8'(bif.reg_escrita), 8'h0);
    rst = 1'b0;

    // add r2,r2 full pass after release, fetched at pc=0
    tick();
    chk("add_pc", bif.pc, 8'h01);
    chk("add_wr_dec", 8'(bif.reg_escrita), 8'h0);
    bif.pronto_mem = 1'b0;
    tick();
    chk("add_ula", 8'(bif.sinal_ula), 8'h2);
    chk("add_f1", 8'(bif.reg_fonte1), 8'h2);
    chk("add_f2", 8'(bif.reg_fonte2), 8'h2);
    chk("add_dest", 8'(bif.reg_destino), 8'h2);
    chk("add_sel", 8'(bif.sel_imediato), 8'h0);
    chk("add_wr_exec", 8'(bif.reg_escrita), 8'h0);
    tick();
    chk("add_wr_pulse", 8'(bif.reg_escrita), 8'h1);
    tick();
    chk("add_wr_end", 8'(bif.reg_escrita), 8'h0);
    chk("add_pc_end", bif.pc, 8'h01);

    // addi r1,7
    bif.instrucao  = 8'hAF;
    bif.pronto_mem = 1'b1;
    tick();
    chk("addi_pc", bif.pc, 8'h02);
    bif.pronto_mem = 1'b0;
    tick();
    chk("addi_sel", 8'(bif.sel_imediato), 8'h1);
    chk("addi_imm", bif.imediato, 8'h07);
    chk("addi_ula", 8'(bif.sinal_ula), 8'h2);
    chk("addi_dest", 8'(bif.reg_destino), 8'h1);
    chk("addi_f1", 8'(bif.reg_fonte1), 8'h1);
    tick();
    chk("addi_wr_pulse", 8'(bif.reg_escrita), 8'h1);
    tick();
    chk("addi_wr_end", 8'(bif.reg_escrita), 8'h0);

    // beq r0,r1 taken
    do_reset();
    bif.instrucao  = 8'hC2;
    bif.pronto_mem = 1'b1;
    tick();
    bif.pronto_mem = 1'b0;
    bif.zero       = 1'b1;
    tick();
    chk("beq_ula", 8'(bif.sinal_ula), 8'h3);
    chk("beq_f1", 8'(bif.reg_fonte1), 8'h0);
    chk("beq_f2", 8'(bif.reg_fonte2), 8'h1);
    chk("beq_sel", 8'(bif.sel_imediato), 8'h0);
    tick();
    bif.zero = 1'b0;
    chk("beq_taken_pc", bif.pc, 8'h02);
    chk("beq_taken_wr", 8'(bif.reg_escrita), 8'h0);
    tick();
    chk("beq_taken_wr2", 8'(bif.reg_escrita), 8'h0);

    // beq not taken; zero high only during decode must be ignored
    do_reset();
    bif.instrucao  = 8'hC2;
    bif.pronto_mem = 1'b1;
    tick();
    bif.pronto_mem = 1'b0;
    bif.zero       = 1'b1;
    tick();
    bif.zero = 1'b0;
    tick();
    chk("beq_nt_pc", bif.pc, 8'h01);
    tick();
    chk("beq_nt_wr", 8'(bif.reg_escrita), 8'h0);

    // 3-cycle memory stall then and r1,r0
    chk("stall_pc0", bif.pc, 8'h01);
    bif.instrucao = 8'h08;
    tick();
    chk("stall_pc1", bif.pc, 8'h01);
    tick();
    chk("stall_pc2", bif.pc, 8'h01);
    chk("stall_ula", 8'(bif.sinal_ula), 8'h3);
    bif.pronto_mem = 1'b1;
    tick();
    chk("stall_fetch_pc", bif.pc, 8'h02);
    bif.pronto_mem = 1'b0;
    tick();
    chk("and_ula", 8'(bif.sinal_ula), 8'h0);
    chk("and_dest", 8'(bif.reg_destino), 8'h1);
    chk("and_f2", 8'(bif.reg_fonte2), 8'h0);
    tick();
    chk("and_wr_pulse", 8'(bif.reg_escrita), 8'h1);
    tick();
    chk("and_wr_end", 8'(bif.reg_escrita), 8'h0);

    // halt at pc=255
    run_to_255();
    chk("reach_255", bif.pc, 8'hFF);
    bif.instrucao  = 8'hE0;
    bif.pronto_mem = 1'b1;
    tick();
    chk("halt_pc_wrap", bif.pc, 8'h00);
    chk("halt_parado_1", 8'(bif.parado), 8'h0);
    bif.instrucao = 8'h54;
    tick();
    chk("halt_parado_2", 8'(bif.parado), 8'h1);
    for (int i = 0; i < 4; i++) begin
      bif.pronto_mem = (i % 2 == 0);
      tick();
      chk("halt_sticky", 8'(bif.parado), 8'h1);
      chk("halt_pc_hold", bif.pc, 8'h00);
      chk("halt_no_wr", 8'(bif.reg_escrita), 8'h0);
    end
    bif.pronto_mem = 1'b0;
    do_reset();
    chk("halt_cleared", 8'(bif.parado), 8'h0);

    // skip from 255 lands on 1
    run_to_255();
    bif.instrucao  = 8'hC2;
    bif.pronto_mem = 1'b1;
    tick();
    chk("skip255_fetch", bif.pc, 8'h00);
    bif.pronto_mem = 1'b0;
    bif.zero       = 1'b1;
    tick();
    tick();
    chk("skip255_pc", bif.pc, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
